// File: rtl/io_uart_pkg.sv
// Shared definitions for the UART peripheral: register map, STATUS bit layout,
// IO base addresses and FSM state encodings.
`timescale 1ns/1ps
package io_uart_pkg;

    localparam logic [1:0] UART_DATA    = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_TX_BUSY   = 5;

    // IO device windows, four registers each
    localparam logic [7:0] UART_BASE  = 8'h10;
    localparam logic [7:0] TIMER_BASE = 8'h20;
    localparam logic [7:0] GPIO_BASE  = 8'h30;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/io_uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is only
// accepted when a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the 8-bit IO bus: TX FIFO + serializer, RX
// deserializer into a one-byte holding register, STATUS/DIVISOR/CTRL registers.
`timescale 1ns/1ps
module io_uart
    import io_uart_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = UART_BASE,
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    logic        sel;
    logic [1:0]  reg_idx;
    logic        rd_access;
    logic        wr_access;
    logic        data_rd;
    logic        data_wr;
    logic        status_wr;

    logic [15:0] divisor;
    logic        ie_rx;
    logic        ie_tx;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shreg, tx_shreg_n;
    logic        tx_busy;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shreg, rx_shreg_n;
    logic        rx_meta, rx_sync, rx_prev;
    logic        rx_done;
    logic [16:0] div_plus1;
    logic [15:0] half_bit;
    logic [5:0]  status_bits;
    logic        unused_wdata;

    assign sel       = io_en && (io_addr[7:2] == BASE_ADDR[7:2]);
    assign reg_idx   = io_addr[1:0];
    assign rd_access = sel && !io_we;
    assign wr_access = sel && io_we;
    assign data_rd   = rd_access && (reg_idx == UART_DATA);
    assign data_wr   = wr_access && (reg_idx == UART_DATA);
    assign status_wr = wr_access && (reg_idx == UART_STATUS);
    assign unused_wdata = ^io_data_write[31:16];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (fifo_pop),
        .din   (io_data_write[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor <= DEFAULT_DIV;
            ie_rx   <= 1'b0;
            ie_tx   <= 1'b0;
        end else if (wr_access) begin
            if (reg_idx == UART_DIVISOR) divisor <= io_data_write[15:0];
            if (reg_idx == UART_CTRL) begin
                ie_rx <= io_data_write[0];
                ie_tx <= io_data_write[1];
            end
        end
    end

    // TX: pop on entry to START; every state is reloaded from DIVISOR, so new
    // divisor values take effect at the next bit boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shreg <= tx_shreg_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = divisor;
                    tx_shreg_n = fifo_dout;
                    fifo_pop   = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = divisor;
                    tx_bit_n   = 3'd0;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n = divisor;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shreg_n = {1'b0, tx_shreg[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == 16'd0) begin
                    if (!fifo_empty) begin
                        tx_state_n = TX_START;
                        tx_cnt_n   = divisor;
                        tx_shreg_n = fifo_dout;
                        fifo_pop   = 1'b1;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE);

    always_comb begin
        case (tx_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shreg[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign div_plus1 = {1'b0, divisor} + 17'd1;
    assign half_bit  = div_plus1[16:1];

    // RX: START checks the line at half-bit to reject glitches, then each
    // following sample lands one full bit later
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync && rx_prev) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = half_bit;
                end
            end
            RX_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = divisor;
                        rx_bit_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_shreg_n = {rx_sync, rx_shreg[7:1]};
                    rx_cnt_n   = divisor;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_done    = 1'b1;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A completion outranks a simultaneous DATA read or W1C; a read in the
    // completion cycle still sees the old byte and does not count as overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done) rx_byte <= rx_shreg;

            if (rx_done)      rx_valid <= 1'b1;
            else if (data_rd) rx_valid <= 1'b0;

            if (rx_done && rx_valid && !data_rd)
                overrun <= 1'b1;
            else if (status_wr && io_data_write[ST_OVERRUN])
                overrun <= 1'b0;

            if (rx_done && !rx_sync)
                frame_err <= 1'b1;
            else if (status_wr && io_data_write[ST_FRAME_ERR])
                frame_err <= 1'b0;
        end
    end

    always_comb begin
        status_bits               = '0;
        status_bits[ST_TX_FULL]   = fifo_full;
        status_bits[ST_TX_EMPTY]  = fifo_empty;
        status_bits[ST_RX_VALID]  = rx_valid;
        status_bits[ST_OVERRUN]   = overrun;
        status_bits[ST_FRAME_ERR] = frame_err;
        status_bits[ST_TX_BUSY]   = tx_busy;
    end

    always_comb begin
        io_data_read = '0;
        if (rd_access) begin
            case (reg_idx)
                UART_DATA:    io_data_read = {24'b0, rx_byte};
                UART_STATUS:  io_data_read = {26'b0, status_bits};
                UART_DIVISOR: io_data_read = {16'b0, divisor};
                default:      io_data_read = {30'b0, ie_tx, ie_rx};
            endcase
        end
    end

    assign irq = (rx_valid && ie_rx) || (fifo_empty && ie_tx);

endmodule

// File: tb/tb_io_uart.sv
// Directed self-checking bench for io_uart: register access, TX framing,
// FIFO fill/drop, loopback reception, overrun, framing error and reset abort.
`timescale 1ns/1ps
module tb_io_uart;

    localparam logic [7:0] A_DATA    = 8'h10;
    localparam logic [7:0] A_STATUS  = 8'h11;
    localparam logic [7:0] A_DIVISOR = 8'h12;
    localparam logic [7:0] A_CTRL    = 8'h13;
    localparam logic [7:0] A_OTHER   = 8'h20;

    logic        clk;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq;

    logic        loopback;
    logic        rx_drive;
    int          cyc;
    int          rd_cyc;
    int          checks;
    int          failures;

    assign uart_rx = loopback ? uart_tx : rx_drive;

    io_uart dut (
        .clk           (clk),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .irq           (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Bus tasks are entered 1 ns after a rising edge and return 1 ns after the
    // edge that commits the access.
    task automatic io_write(input logic [7:0] addr, input logic [31:0] data);
        io_addr       = addr;
        io_we         = 1'b1;
        io_en         = 1'b1;
        io_data_write = data;
        @(posedge clk);
        #1;
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [31:0] data);
        io_addr = addr;
        io_we   = 1'b0;
        io_en   = 1'b1;
        #1;
        data   = io_data_read;
        rd_cyc = cyc;
        @(posedge clk);
        #1;
        io_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = frame[k];
            repeat (4) @(posedge clk);
            #1;
        end
        rx_drive = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b want 1", uart_tx); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
        checks++;
        if (io_data_read !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0", io_data_read); end
        reset = 1'b0;
        io_read(A_STATUS, r);
        checks++;
        if (r !== 32'h2) begin failures++; $display("[TB] FAIL reset_status: got %h want 00000002", r); end
        io_read(A_DIVISOR, r);
        checks++;
        if (r !== 32'd433) begin failures++; $display("[TB] FAIL reset_divisor: got %0d want 433", r); end
        io_read(A_CTRL, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("[TB] FAIL reset_ctrl: got %h want 0", r); end
        io_read(A_OTHER, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("[TB] FAIL unselected_read: got %h want 0", r); end
        io_write(A_CTRL, 32'h3);
        io_read(A_CTRL, r);
        checks++;
        if (r !== 32'h3) begin failures++; $display("[TB] FAIL ctrl_readback: got %h want 3", r); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_tx_empty: got %b want 1", irq); end
        io_write(A_CTRL, 32'h0);
    endtask

    task automatic test_tx_frame();
        logic [31:0] r;
        logic        tx_s [60];
        logic        busy_s [60];
        logic [9:0]  frame;
        int          busy_cnt;
        int          bad;
        do_reset();
        io_write(A_DIVISOR, 32'd3);
        io_read(A_DIVISOR, r);
        checks++;
        if (r !== 32'd3) begin failures++; $display("[TB] FAIL divisor_readback: got %0d want 3", r); end
        io_write(A_DATA, 32'h55);
        io_addr = A_STATUS;
        io_we   = 1'b0;
        io_en   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            tx_s[k]   = uart_tx;
            busy_s[k] = io_data_read[5];
        end
        io_en = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) busy_cnt += (busy_s[k] === 1'b1) ? 1 : 0;
        checks++;
        if (busy_cnt != 40) begin failures++; $display("[TB] FAIL tx_busy_len: got %0d want 40", busy_cnt); end
        checks++;
        if (busy_s[0] !== 1'b1 || busy_s[39] !== 1'b1 || busy_s[40] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tx_busy_window: got %b%b%b want 110", busy_s[0], busy_s[39], busy_s[40]);
        end
        frame = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int j = 0; j < 4; j++) if (tx_s[4*b+j] !== frame[b]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("[TB] FAIL tx_bit%0d: got %b%b%b%b want %b x4", b,
                         tx_s[4*b], tx_s[4*b+1], tx_s[4*b+2], tx_s[4*b+3], frame[b]);
            end
        end
        bad = 0;
        for (int k = 40; k < 60; k++) if (tx_s[k] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL tx_idle_after: got %0d low samples want 0", bad); end
    endtask

    task automatic test_fifo_fill();
        logic [31:0] r;
        logic [7:0]  got [10];
        logic [7:0]  exp_b [9];
        int          t0, t1, got_n;
        bit          pending, seen_idle;
        do_reset();
        loopback = 1'b1;
        io_write(A_DIVISOR, 32'd3);
        io_write(A_DATA, 32'h11);
        t0 = cyc;
        for (int i = 0; i < 7; i++) io_write(A_DATA, 32'h21 + i);
        io_read(A_STATUS, r);
        checks++;
        if (r[0] !== 1'b0) begin failures++; $display("[TB] FAIL full_after7: got %b want 0", r[0]); end
        io_write(A_DATA, 32'h28);
        io_read(A_STATUS, r);
        checks++;
        if (r[1:0] !== 2'b01) begin failures++; $display("[TB] FAIL full_after8: got %b want 01", r[1:0]); end
        io_write(A_DATA, 32'h99);
        io_read(A_STATUS, r);
        checks++;
        if (r[0] !== 1'b1) begin failures++; $display("[TB] FAIL full_after9: got %b want 1", r[0]); end

        got_n = 0; pending = 0; seen_idle = 0; t1 = 0;
        for (int i = 0; i < 700; i++) begin
            if (got_n >= 9 && seen_idle) break;
            if (pending) begin
                io_read(A_DATA, r);
                if (got_n < 10) got[got_n] = r[7:0];
                got_n++;
                pending = 0;
            end else begin
                io_read(A_STATUS, r);
                if (!r[5] && !seen_idle) begin
                    seen_idle = 1;
                    t1 = rd_cyc;
                end
                if (r[2]) pending = 1;
            end
        end
        checks++;
        if (got_n != 9) begin failures++; $display("[TB] FAIL fifo_rx_count: got %0d want 9", got_n); end
        exp_b[0] = 8'h11;
        for (int i = 1; i < 9; i++) exp_b[i] = 8'h20 + 8'(i);
        for (int i = 0; i < 9 && i < got_n; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL fifo_byte%0d: got %h want %h", i, got[i], exp_b[i]);
            end
        end
        checks++;
        if (!seen_idle || (t1 - t0) != 361) begin
            failures++;
            $display("[TB] FAIL back_to_back: got %0d cycles (seen=%0b) want 361", t1 - t0, seen_idle);
        end
        repeat (60) @(posedge clk);
        #1;
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h02) begin failures++; $display("[TB] FAIL no_ninth_byte: got %h want 02", r[5:0]); end
    endtask

    task automatic test_loopback();
        logic [31:0] r;
        bit          seen;
        do_reset();
        loopback = 1'b1;
        io_write(A_DIVISOR, 32'd3);
        io_write(A_CTRL, 32'h1);
        io_write(A_DATA, 32'hA5);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            io_read(A_STATUS, r);
            if (r[2]) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL loop_rx_valid: got 0 want 1"); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_rx: got %b want 1", irq); end
        io_read(A_DATA, r);
        checks++;
        if (r !== 32'h000000A5) begin failures++; $display("[TB] FAIL loop_data: got %h want 000000a5", r); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_rx_clear: got %b want 0", irq); end
        io_read(A_STATUS, r);
        checks++;
        if (r[2] !== 1'b0) begin failures++; $display("[TB] FAIL loop_valid_clear: got %b want 0", r[2]); end
        io_write(A_CTRL, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        do_reset();
        loopback = 1'b1;
        io_write(A_DIVISOR, 32'd3);
        io_write(A_DATA, 32'h3C);
        io_write(A_DATA, 32'hC3);
        repeat (120) @(posedge clk);
        #1;
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h0E) begin failures++; $display("[TB] FAIL overrun_status: got %h want 0e", r[5:0]); end
        io_write(A_STATUS, 32'h07);
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h0E) begin failures++; $display("[TB] FAIL w1c_ignored_bits: got %h want 0e", r[5:0]); end
        io_read(A_DATA, r);
        checks++;
        if (r !== 32'h000000C3) begin failures++; $display("[TB] FAIL overrun_data: got %h want 000000c3", r); end
        io_write(A_STATUS, 32'h08);
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h02) begin failures++; $display("[TB] FAIL overrun_clear: got %h want 02", r[5:0]); end
    endtask

    task automatic test_frame_error();
        logic [31:0] r;
        do_reset();
        rx_drive = 1'b1;
        loopback = 1'b0;
        io_write(A_DIVISOR, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        drive_frame(8'h6E, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h16) begin failures++; $display("[TB] FAIL frame_err_status: got %h want 16", r[5:0]); end
        io_read(A_DATA, r);
        checks++;
        if (r !== 32'h0000006E) begin failures++; $display("[TB] FAIL frame_err_data: got %h want 0000006e", r); end
        io_write(A_STATUS, 32'h10);
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h02) begin failures++; $display("[TB] FAIL frame_err_clear: got %h want 02", r[5:0]); end
        rx_drive = 1'b0;
        @(posedge clk);
        #1;
        rx_drive = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        io_read(A_STATUS, r);
        checks++;
        if (r[5:0] !== 6'h02) begin failures++; $display("[TB] FAIL glitch_reject: got %h want 02", r[5:0]); end
        loopback = 1'b1;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int          bad;
        do_reset();
        loopback = 1'b1;
        io_write(A_DIVISOR, 32'd3);
        io_write(A_CTRL, 32'h3);
        io_write(A_DATA, 32'h00);
        io_write(A_DATA, 32'h7E);
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("[TB] FAIL pre_reset_bit3: got %b want 0", uart_tx); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("[TB] FAIL abort_tx: got %b want 1", uart_tx); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL abort_irq: got %b want 0", irq); end
        reset = 1'b0;
        io_read(A_STATUS, r);
        checks++;
        if (r !== 32'h2) begin failures++; $display("[TB] FAIL abort_status: got %h want 00000002", r); end
        io_read(A_DIVISOR, r);
        checks++;
        if (r !== 32'd433) begin failures++; $display("[TB] FAIL abort_divisor: got %0d want 433", r); end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL abort_tx_idle: got %0d low samples want 0", bad); end
    endtask

    initial begin
        cyc           = 0;
        rd_cyc        = 0;
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        io_addr       = 8'h0;
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_data_write = 32'h0;
        loopback      = 1'b1;
        rx_drive      = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_tx_frame();
        test_fifo_fill();
        test_loopback();
        test_overrun();
        test_frame_error();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
